// File: rtl/tmds_pkg.sv
// ============================================================
// Module  : tmds_pkg
// Brief   : TMDS control tokens, alignment states, data decode.
// Revision: 1.0
// ============================================================
`default_nettype none

package tmds_pkg;

  localparam logic [9:0] c_tok_ctl00 = 10'b1101010100;
  localparam logic [9:0] c_tok_ctl01 = 10'b0010101011;
  localparam logic [9:0] c_tok_ctl10 = 10'b0101010100;
  localparam logic [9:0] c_tok_ctl11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  function automatic logic [7:0] tmds_decode_data(input logic [9:0] word);
    logic [7:0] w_d;
    logic [7:0] w_q;
    w_d    = word[9] ? ~word[7:0] : word[7:0];
    w_q    = 8'h00;
    w_q[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_q[i] = word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
    return w_q;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_word_align.sv
// ============================================================
// Module  : tmds_word_align
// Brief   : Word-boundary search FSM driving deserializer bitslip.
// Revision: 1.0
// ============================================================
`default_nettype none

module tmds_word_align #(
  parameter int LOCK_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 8,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic is_ctl,
  output logic lock_nxt,
  output logic BITSLIP,
  output logic LOCKED
);
  import tmds_pkg::*;

  localparam int c_tmr_max0 = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int c_tmr_max1 = (c_tmr_max0 > SLIP_WAIT) ? c_tmr_max0 : SLIP_WAIT;
  localparam int c_tmr_max  = (c_tmr_max1 > 2) ? c_tmr_max1 : 2;
  localparam int c_tmr_w    = $clog2(c_tmr_max);
  localparam int c_run_w    = $clog2(LOCK_RUN + 1);

  localparam logic [c_tmr_w-1:0] c_search_last = c_tmr_w'(SEARCH_TIMEOUT - 1);
  localparam logic [c_tmr_w-1:0] c_wait_last   = c_tmr_w'(SLIP_WAIT - 1);
  localparam logic [c_tmr_w-1:0] c_loss_last   = c_tmr_w'(LOSS_TIMEOUT - 1);
  localparam logic [c_run_w-1:0] c_run_last    = c_run_w'(LOCK_RUN - 1);
  localparam logic [c_run_w-1:0] c_run_sat     = c_run_w'(LOCK_RUN);

  align_state_t        r_state;
  align_state_t        w_state_nxt;
  logic [c_tmr_w-1:0]  r_timer;
  logic [c_tmr_w-1:0]  w_timer_nxt;
  logic [c_tmr_w-1:0]  w_timer_inc;
  logic [c_run_w-1:0]  r_run;
  logic [c_run_w-1:0]  w_run_nxt;
  logic [c_run_w-1:0]  w_run_inc;
  logic                r_bitslip;
  logic                r_locked;

  assign w_timer_inc = (r_timer == {c_tmr_w{1'b1}}) ? r_timer : r_timer + c_tmr_w'(1);
  assign w_run_inc   = (r_run == c_run_sat) ? r_run : r_run + c_run_w'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_run_nxt   = r_run;
    case (r_state)
      ST_SEARCH: begin
        w_run_nxt   = is_ctl ? w_run_inc : '0;
        w_timer_nxt = w_timer_inc;
        // A completed token run wins over a coincident search timeout.
        if (is_ctl && (r_run == c_run_last)) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
          w_run_nxt   = '0;
        end else if (r_timer == c_search_last) begin
          w_state_nxt = ST_SLIP;
          w_timer_nxt = '0;
          w_run_nxt   = '0;
        end
      end
      ST_SLIP: begin
        w_state_nxt = ST_WAIT;
        w_timer_nxt = '0;
      end
      ST_WAIT: begin
        if (r_timer == c_wait_last) begin
          w_state_nxt = ST_SEARCH;
          w_timer_nxt = '0;
          w_run_nxt   = '0;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      ST_LOCKED: begin
        if (is_ctl) begin
          w_timer_nxt = '0;
        end else if (r_timer == c_loss_last) begin
          w_state_nxt = ST_SEARCH;
          w_timer_nxt = '0;
          w_run_nxt   = '0;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_timer_nxt = '0;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= ST_SEARCH;
      r_timer   <= '0;
      r_run     <= '0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_run     <= w_run_nxt;
      r_bitslip <= (w_state_nxt == ST_SLIP);
      r_locked  <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign lock_nxt = (w_state_nxt == ST_LOCKED);
  assign BITSLIP  = r_bitslip;
  assign LOCKED   = r_locked;

endmodule

`default_nettype wire

// File: rtl/tmds_decoder.sv
// ============================================================
// Module  : tmds_decoder
// Brief   : TMDS receive channel: token detect, data decode, outputs.
// Revision: 1.0
// ============================================================
`default_nettype none

module tmds_decoder #(
  parameter int LOCK_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 8,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [9:0] DIN,
  output logic       BITSLIP,
  output logic       LOCKED,
  output logic       DE,
  output logic [1:0] CTL,
  output logic [7:0] DATA
);
  import tmds_pkg::*;

  logic       w_is_ctl;
  logic [1:0] w_ctl_code;
  logic       w_lock_nxt;
  logic       r_de;
  logic [1:0] r_ctl;
  logic [7:0] r_data;

  always_comb begin
    w_is_ctl   = 1'b1;
    w_ctl_code = 2'b00;
    case (DIN)
      c_tok_ctl00: w_ctl_code = 2'b00;
      c_tok_ctl01: w_ctl_code = 2'b01;
      c_tok_ctl10: w_ctl_code = 2'b10;
      c_tok_ctl11: w_ctl_code = 2'b11;
      default:     w_is_ctl   = 1'b0;
    endcase
  end

  tmds_word_align #(
    .LOCK_RUN       (LOCK_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_WAIT      (SLIP_WAIT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) u_align (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .is_ctl   (w_is_ctl),
    .lock_nxt (w_lock_nxt),
    .BITSLIP  (BITSLIP),
    .LOCKED   (LOCKED)
  );

  // DE follows the post-edge state so a loss timeout forces it low at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_de   <= 1'b0;
      r_ctl  <= 2'b00;
      r_data <= 8'h00;
    end else begin
      r_de <= !w_is_ctl && w_lock_nxt;
      if (w_is_ctl) begin
        r_ctl <= w_ctl_code;
      end else begin
        r_data <= tmds_decode_data(DIN);
      end
    end
  end

  assign DE   = r_de;
  assign CTL  = r_ctl;
  assign DATA = r_data;

endmodule

`default_nettype wire

// File: tb/tb_tmds_decoder.sv
// ============================================================
// Module  : tb_tmds_decoder
// Brief   : Directed self-checking bench for tmds_decoder.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_tmds_decoder;

  localparam logic [9:0] c_tok00 = 10'b1101010100;
  localparam logic [9:0] c_tok01 = 10'b0010101011;
  localparam logic [9:0] c_tok10 = 10'b0101010100;
  localparam logic [9:0] c_tok11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] din;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [1:0] ctl;
  logic [7:0] data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tmds_decoder #(
    .LOCK_RUN       (8),
    .SEARCH_TIMEOUT (1024),
    .SLIP_WAIT      (8),
    .LOSS_TIMEOUT   (4096)
  ) dut (
    .CLK     (clk),
    .RSTN    (rstn),
    .DIN     (din),
    .BITSLIP (bitslip),
    .LOCKED  (locked),
    .DE      (de),
    .CTL     (ctl),
    .DATA    (data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [9:0] v);
    @(negedge clk);
    din = v;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    din  = 10'h100;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int slip_edges[$];
    int first_slip;
    bit locked_seen;
    bit slip_seen;

    rstn = 1'b1;
    din  = 10'h100;
    #1 rstn = 1'b0;
    #11;
    check("rst_bitslip", bitslip, 0);
    check("rst_locked",  locked,  0);
    check("rst_de",      de,      0);
    check("rst_ctl",     ctl,     0);
    check("rst_data",    data,    0);
    @(negedge clk);
    rstn = 1'b1;

    // Lock on eight CTL=01 tokens
    for (int i = 1; i <= 8; i++) begin
      drive(c_tok01);
      check($sformatf("lock_run%0d", i), locked, (i == 8));
    end
    check("lock_ctl", ctl, 2'b01);
    check("lock_de",  de,  0);

    drive(10'h100);
    check("dec100_de",   de,   1);
    check("dec100_data", data, 8'h00);
    check("dec100_ctl",  ctl,  2'b01);
    drive(10'h2FF);
    check("dec2ff_de",   de,   1);
    check("dec2ff_data", data, 8'hFE);
    check("dec2ff_ctl",  ctl,  2'b01);

    drive(c_tok10);
    check("tok10_ctl",  ctl,  2'b10);
    check("tok10_de",   de,   0);
    check("tok10_data", data, 8'hFE);
    drive(c_tok11);
    check("tok11_ctl", ctl, 2'b11);
    drive(c_tok00);
    check("tok00_ctl",    ctl,    2'b00);
    check("tok00_locked", locked, 1);

    // Loss of lock after 4096 data words, then relock
    for (int i = 1; i <= 4096; i++) begin
      drive(10'h100);
      if (i == 4095) begin
        check("loss_pre_locked", locked, 1);
        check("loss_pre_de",     de,     1);
      end
      if (i == 4096) begin
        check("loss_locked", locked, 0);
        check("loss_de",     de,     0);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      drive(c_tok01);
      if (i == 7) check("relock7", locked, 0);
      if (i == 8) check("relock8", locked, 1);
    end

    // Broken run: the data word restarts the count
    apply_reset();
    for (int i = 1; i <= 7; i++) drive(c_tok01);
    check("brk_run7_locked", locked, 0);
    drive(10'h2FF);
    check("brk_data_de",     de,     0);
    check("brk_data_data",   data,   8'hFE);
    check("brk_data_locked", locked, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(c_tok01);
      check($sformatf("brk_tok%0d", i), locked, (i == 8));
    end

    // Misaligned stream: periodic bitslip, never locks
    @(negedge clk);
    rstn = 1'b0;
    din  = 10'h3FF;
    @(negedge clk);
    rstn = 1'b1;
    locked_seen = 1'b0;
    for (int k = 0; k < 3200; k++) begin
      @(posedge clk);
      #1;
      if (bitslip) slip_edges.push_back(k);
      if (locked) locked_seen = 1'b1;
    end
    check("mis_count",  slip_edges.size(), 3);
    check("mis_slip0",  (slip_edges.size() > 0) ? slip_edges[0] : -1, 1023);
    check("mis_slip1",  (slip_edges.size() > 1) ? slip_edges[1] : -1, 2056);
    check("mis_slip2",  (slip_edges.size() > 2) ? slip_edges[2] : -1, 3089);
    check("mis_locked", locked_seen, 0);

    // Reset asserted while BITSLIP is high
    slip_seen = 1'b0;
    for (int k = 0; k < 1100 && !slip_seen; k++) begin
      @(posedge clk);
      #1;
      if (bitslip) slip_seen = 1'b1;
    end
    check("slip_seen", slip_seen, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_slip_bitslip", bitslip, 0);
    check("rst_slip_locked",  locked,  0);
    check("rst_slip_de",      de,      0);
    @(negedge clk);
    rstn = 1'b1;
    first_slip = -1;
    for (int k = 0; k < 1024; k++) begin
      @(posedge clk);
      #1;
      if (bitslip && first_slip < 0) first_slip = k;
    end
    check("post_rst_first_slip", first_slip, 1023);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
